// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline boundary in front of the execute-stage ALU. It registers the
// decoded operands and control, then builds the final ALU operands by
// forwarding results from the MEM and WB stages. It also detects load-use
// hazards: decode is held for one cycle and a bubble goes into EX. A flush from
// branch resolution kills the instruction entering EX.
//
// Parameters
//   WIDTH   datapath width, must match the ALU width
//   REG_AW  register-index width
//
// Ports
//   clk, rst_n                    rising-edge clock, synchronous active-low reset
//   valid_d                       decode holds a valid instruction
//   rs1_d, rs2_d, rd_d            source / destination register indices
//   rd1_d, rd2_d                  register-file read data
//   imm_ext_d                     sign-extended immediate
//   alu_cntrl_d, alu_src_d        ALU operation, immediate select for operand B
//   reg_write_d, mem_read_d,
//   mem_write_d                   decoded control bits
//   flush_e                       kill the instruction entering EX
//   rd_m, reg_write_m,
//   alu_result_m                  MEM-stage producer
//   rd_w, reg_write_w, result_w   WB-stage producer
//   stall_d                       hold fetch/decode (combinational)
//   valid_e                       EX holds a valid instruction
//   src_a_e, src_b_e              ALU operands after forwarding and immediate select
//   alu_cntrl_e                   registered ALU control
//   write_data_e                  forwarded rs2 value for stores
//   rd_e                          EX destination register
//   reg_write_e, mem_read_e,
//   mem_write_e                   registered controls, always 0 for a bubble
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    // Decode stage
    input  logic              valid_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic [WIDTH-1:0]  rd1_d,
    input  logic [WIDTH-1:0]  rd2_d,
    input  logic [WIDTH-1:0]  imm_ext_d,
    input  logic [2:0]        alu_cntrl_d,
    input  logic              alu_src_d,
    input  logic              reg_write_d,
    input  logic              mem_read_d,
    input  logic              mem_write_d,

    // Branch resolution
    input  logic              flush_e,

    // Forwarding sources
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [WIDTH-1:0]  alu_result_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic [WIDTH-1:0]  result_w,

    // Hazard control
    output logic              stall_d,

    // Execute stage
    output logic              valid_e,
    output logic [WIDTH-1:0]  src_a_e,
    output logic [WIDTH-1:0]  src_b_e,
    output logic [2:0]        alu_cntrl_e,
    output logic [WIDTH-1:0]  write_data_e,
    output logic [REG_AW-1:0] rd_e,
    output logic              reg_write_e,
    output logic              mem_read_e,
    output logic              mem_write_e
);

    // Source chosen for one forwarded operand.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,   // registered register-file read
        FWD_WB  = 2'd1,   // WB-stage result
        FWD_MEM = 2'd2    // MEM-stage ALU result
    } fwd_sel_e;

    // -------------------------------------------------------------------------
    // EX-stage registers
    // -------------------------------------------------------------------------
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [WIDTH-1:0]  rd1_e;
    logic [WIDTH-1:0]  rd2_e;
    logic [WIDTH-1:0]  imm_e;
    logic              alu_src_e;

    // -------------------------------------------------------------------------
    // Load-use hazard
    // -------------------------------------------------------------------------
    // A load in EX delivers its data only at the end of MEM. An instruction
    // in decode that reads the load's destination has to wait one cycle, and
    // then it picks up the value through WB forwarding. x0 is never written,
    // so a load to x0 cannot create a dependency.
    logic lu_haz;
    logic bubble;

    assign lu_haz = valid_e & mem_read_e & (rd_e != '0) & valid_d &
                    ((rd_e == rs1_d) | (rd_e == rs2_d));

    // When the dependent instruction is being flushed there is nothing to
    // wait for, so the flush also cancels the stall.
    assign stall_d = lu_haz & ~flush_e;

    // Both a flush and a load-use hazard put an empty slot into EX.
    assign bubble  = flush_e | lu_haz;

    // -------------------------------------------------------------------------
    // Control registers: a bubble clears every bit that has a side effect.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples the pre-edge values, whatever the order of the statements.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_e     <= 1'b0;
            reg_write_e <= 1'b0;
            mem_read_e  <= 1'b0;
            mem_write_e <= 1'b0;
            alu_cntrl_e <= '0;
        end else if (bubble) begin
            valid_e     <= 1'b0;
            reg_write_e <= 1'b0;
            mem_read_e  <= 1'b0;
            mem_write_e <= 1'b0;
            alu_cntrl_e <= '0;
        end else begin
            valid_e     <= valid_d;
            reg_write_e <= reg_write_d & valid_d;
            mem_read_e  <= mem_read_d  & valid_d;
            mem_write_e <= mem_write_d & valid_d;
            alu_cntrl_e <= valid_d ? alu_cntrl_d : 3'b000;
        end
    end

    // -------------------------------------------------------------------------
    // Data registers
    // -------------------------------------------------------------------------
    // The data registers load on every cycle. During a bubble their contents
    // do not matter: every control bit is 0, and decode presents the held
    // instruction again on the next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            imm_e     <= '0;
            alu_src_e <= 1'b0;
        end else begin
            rs1_e     <= rs1_d;
            rs2_e     <= rs2_d;
            rd_e      <= rd_d;
            rd1_e     <= rd1_d;
            rd2_e     <= rd2_d;
            imm_e     <= imm_ext_d;
            alu_src_e <= alu_src_d;
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding select
    // -------------------------------------------------------------------------
    // MEM holds the newer value, so it wins over WB. x0 is excluded at the
    // producer side: a producer that targets x0 never forwards.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_mem,
        input logic              we_mem,
        input logic [REG_AW-1:0] rd_wb,
        input logic              we_wb
    );
        if (we_mem && (rd_mem != '0) && (rd_mem == rs)) begin
            return FWD_MEM;
        end else if (we_wb && (rd_wb != '0) && (rd_wb == rs)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

    fwd_sel_e   sel_a;
    fwd_sel_e   sel_b;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    assign sel_a = fwd_select(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    assign sel_b = fwd_select(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

    // NOTE: every output of a combinational block gets a default first.
    // Then no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        fwd_a = rd1_e;
        unique case (sel_a)
            FWD_MEM: fwd_a = alu_result_m;
            FWD_WB:  fwd_a = result_w;
            default: fwd_a = rd1_e;
        endcase
    end

    always_comb begin
        fwd_b = rd2_e;
        unique case (sel_b)
            FWD_MEM: fwd_b = alu_result_m;
            FWD_WB:  fwd_b = result_w;
            default: fwd_b = rd2_e;
        endcase
    end

    // -------------------------------------------------------------------------
    // Operand outputs
    // -------------------------------------------------------------------------
    // A store takes its immediate on B and its data from rs2, so write_data_e
    // always carries the forwarded rs2 value and ignores alu_src_e.
    assign src_a_e      = fwd_a;
    assign src_b_e      = alu_src_e ? imm_e : fwd_b;
    assign write_data_e = fwd_b;

endmodule
